// File: rtl/gen_chk_phy_tx.sv
// Burst traffic generator for the phy_tx path with an independent loopback checker.
// The checker regenerates the same word sequence and counts rx words and mismatches.
module gen_chk_phy_tx #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned GAP_LEN    = 2,
  parameter int unsigned NUM_BURSTS = 3,
  parameter logic [31:0] SEED       = 32'hFFFFFFFF,
  parameter logic [31:0] STEP       = 32'h11111111,
  parameter logic [31:0] POLY       = 32'h80200003,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] data_out_tx,
  output logic              valid_out_tx,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] data_in_rx,
  input  logic              valid_in_rx,
  output logic              mismatch,
  output logic [CNT_W-1:0]  tx_count,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [DATA_W-1:0] SEED_W = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] STEP_W = DATA_W'(STEP);
  localparam logic [DATA_W-1:0] POLY_W = DATA_W'(POLY);

  localparam int unsigned BEAT_W = (BURST_LEN > 32'd1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned GAP_W  = (GAP_LEN > 32'd1) ? $clog2(GAP_LEN) : 1;
  localparam int unsigned BCNT_W = (NUM_BURSTS > 32'd1) ? $clog2(NUM_BURSTS) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 32'd1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_LEN > 32'd0) ? GAP_LEN - 32'd1 : 32'd0);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'((NUM_BURSTS > 32'd0) ? NUM_BURSTS - 32'd1 : 32'd0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] next_word(input logic [DATA_W-1:0] cur,
                                                  input logic [1:0]        m);
    logic [DATA_W-1:0] nxt;
    case (m)
      2'b00:   nxt = cur + DATA_W'(1);
      2'b01:   nxt = cur - STEP_W;
      2'b10:   nxt = cur[0] ? ((cur >> 1) ^ POLY_W) : (cur >> 1);
      2'b11:   nxt = cur;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // An all-zero LFSR state would never leave zero, so it starts from 1 instead.
  function automatic logic [DATA_W-1:0] seed_word(input logic [1:0] m);
    logic [DATA_W-1:0] s;
    if ((m == 2'b10) && (SEED_W == {DATA_W{1'b0}})) begin
      s = DATA_W'(1);
    end else begin
      s = SEED_W;
    end
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  state_t            state_r, state_s;
  logic [1:0]        mode_r;
  logic [DATA_W-1:0] gen_r, chk_r;
  logic [BEAT_W-1:0] beat_r;
  logic [GAP_W-1:0]  gap_r;
  logic [BCNT_W-1:0] burst_r;

  logic [DATA_W-1:0] data_out_tx_r;
  logic              valid_out_tx_r, busy_r, done_r, mismatch_r;
  logic [CNT_W-1:0]  tx_count_r, rx_count_r, err_count_r;

  logic load_s, emit_s, last_beat_s, last_burst_s, gap_end_s;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (load_s) begin
          state_s = ST_BURST;
        end else begin
          state_s = state_r;
        end
      end
      ST_BURST: begin
        if (!last_beat_s) begin
          state_s = ST_BURST;
        end else if (last_burst_s) begin
          state_s = ST_DONE;
        end else if (GAP_LEN == 32'd0) begin
          state_s = ST_BURST;
        end else begin
          state_s = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_end_s) begin
          state_s = ST_BURST;
        end else begin
          state_s = ST_GAP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Control decode from the current state.
  always_comb begin
    load_s       = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    emit_s       = (state_r == ST_BURST);
    last_beat_s  = emit_s && (beat_r == BEAT_LAST);
    last_burst_s = (NUM_BURSTS != 32'd0) && (burst_r == BCNT_LAST);
    gap_end_s    = (state_r == ST_GAP) && (gap_r == GAP_LAST);
  end

  // Generator datapath and registered tx-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r         <= 2'b00;
      gen_r          <= SEED_W;
      beat_r         <= '0;
      gap_r          <= '0;
      burst_r        <= '0;
      data_out_tx_r  <= '0;
      valid_out_tx_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      tx_count_r     <= '0;
    end else begin
      valid_out_tx_r <= emit_s;
      busy_r         <= (state_r == ST_BURST) || (state_r == ST_GAP);
      done_r         <= (state_r == ST_DONE);
      if (load_s) begin
        mode_r     <= mode;
        gen_r      <= seed_word(mode);
        beat_r     <= '0;
        gap_r      <= '0;
        burst_r    <= '0;
        tx_count_r <= '0;
      end else if (emit_s) begin
        data_out_tx_r <= gen_r;
        gen_r         <= next_word(gen_r, mode_r);
        tx_count_r    <= sat_inc(tx_count_r);
        if (last_beat_s) begin
          beat_r <= '0;
          gap_r  <= '0;
          if ((NUM_BURSTS != 32'd0) && !last_burst_s) begin
            burst_r <= burst_r + BCNT_W'(1);
          end
        end else begin
          beat_r <= beat_r + BEAT_W'(1);
        end
      end else if (state_r == ST_GAP) begin
        gap_r <= gap_r + GAP_W'(1);
      end
    end
  end

  // Loopback checker; runs in every state so late words are still compared.
  always_ff @(posedge clk) begin
    if (reset) begin
      chk_r       <= SEED_W;
      rx_count_r  <= '0;
      err_count_r <= '0;
      mismatch_r  <= 1'b0;
    end else if (load_s) begin
      chk_r       <= seed_word(mode);
      rx_count_r  <= '0;
      err_count_r <= '0;
      mismatch_r  <= 1'b0;
    end else if (valid_in_rx) begin
      chk_r      <= next_word(chk_r, mode_r);
      rx_count_r <= sat_inc(rx_count_r);
      if (data_in_rx != chk_r) begin
        err_count_r <= sat_inc(err_count_r);
        mismatch_r  <= 1'b1;
      end else begin
        mismatch_r  <= 1'b0;
      end
    end else begin
      mismatch_r <= 1'b0;
    end
  end

  assign data_out_tx  = data_out_tx_r;
  assign valid_out_tx = valid_out_tx_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign mismatch     = mismatch_r;
  assign tx_count     = tx_count_r;
  assign rx_count     = rx_count_r;
  assign err_count    = err_count_r;

endmodule

// File: tb/tb_gen_chk_phy_tx.sv
// Directed bench: a per-cycle vector table for a default-shaped instance, plus
// hand sequences on a zero-seed, gapless, narrow-counter instance.
module tb_gen_chk_phy_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: SEED=FFFFFFFE, 3 bursts of 4, 2-cycle gaps, 16-bit counters.
  logic        start_a, rxv_a, valid_a, busy_a, done_a, mm_a;
  logic [1:0]  mode_a;
  logic [31:0] rxd_a, data_a;
  logic [15:0] tx_a, rx_a, err_a;

  gen_chk_phy_tx #(.SEED(32'hFFFFFFFE)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .mode(mode_a),
    .data_out_tx(data_a), .valid_out_tx(valid_a), .busy(busy_a), .done(done_a),
    .data_in_rx(rxd_a), .valid_in_rx(rxv_a), .mismatch(mm_a),
    .tx_count(tx_a), .rx_count(rx_a), .err_count(err_a)
  );

  // Instance B: SEED=0, 2 bursts of 2, no gap, 3-bit counters.
  logic        start_b, rxv_b, valid_b, busy_b, done_b, mm_b;
  logic [1:0]  mode_b;
  logic [31:0] rxd_b, data_b;
  logic [2:0]  tx_b, rx_b, err_b;

  gen_chk_phy_tx #(.BURST_LEN(2), .GAP_LEN(0), .NUM_BURSTS(2), .SEED(32'h0), .CNT_W(3)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode_b),
    .data_out_tx(data_b), .valid_out_tx(valid_b), .busy(busy_b), .done(done_b),
    .data_in_rx(rxd_b), .valid_in_rx(rxv_b), .mismatch(mm_b),
    .tx_count(tx_b), .rx_count(rx_b), .err_count(err_b)
  );

  typedef struct {
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic        rxv;
    logic [31:0] rxd;
    logic        ev;
    logic [31:0] ed;
    logic        eb;
    logic        edn;
    logic        emm;
    logic [15:0] etx;
    logic [15:0] erx;
    logic [15:0] eerr;
  } vec_t;

  vec_t vq[$];
  int errors = 0;
  int checks = 0;

  task automatic add_vec(input logic rst, input logic st, input logic [1:0] md,
                         input logic rv, input logic [31:0] rd,
                         input logic ev, input logic [31:0] ed, input logic eb,
                         input logic edn, input logic emm,
                         input logic [15:0] etx, input logic [15:0] erx, input logic [15:0] eerr);
    vec_t v;
    v.rst = rst; v.start = st; v.mode = md; v.rxv = rv; v.rxd = rd;
    v.ev = ev; v.ed = ed; v.eb = eb; v.edn = edn; v.emm = emm;
    v.etx = etx; v.erx = erx; v.eerr = eerr;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic b_run(input string nm, input logic [1:0] m, input logic [3:0][31:0] w);
    @(negedge clk);
    start_b = 1'b1; mode_b = m; rxv_b = 1'b0; rxd_b = 32'h0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start_b = 1'b0;
      mode_b  = ~m;
      rxv_b   = (i > 0);
      rxd_b   = w[(i == 0) ? 0 : i - 1];
      @(posedge clk); #1;
      check($sformatf("%s_word%0d", nm, i), {95'd0, valid_b, data_b}, {95'd0, 1'b1, w[i]});
    end
    @(negedge clk);
    rxv_b = 1'b1; rxd_b = w[3];
    @(posedge clk); #1;
    check($sformatf("%s_final", nm), {116'd0, valid_b, busy_b, done_b, tx_b, rx_b, err_b},
          {116'd0, 1'b0, 1'b0, 1'b1, 3'd4, 3'd4, 3'd0});
    @(negedge clk);
    rxv_b = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; mode_a = 2'b00; rxv_a = 1'b0; rxd_a = 32'h0;
    start_b = 1'b0; mode_b = 2'b00; rxv_b = 1'b0; rxd_b = 32'h0;

    //       rst  st   mode   rxv  rxd            ev   ed             busy done mm    tx      rx      err
    add_vec(1'b1, 1'b0, 2'd0, 1'b0, 32'h0,        1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 16'd0,  16'd0, 16'd0);
    add_vec(1'b0, 1'b1, 2'd0, 1'b0, 32'h0,        1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 16'd0,  16'd0, 16'd0);
    add_vec(1'b0, 1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 16'd1,  16'd0, 16'd0);
    add_vec(1'b0, 1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 16'd2,  16'd0, 16'd0);
    add_vec(1'b0, 1'b0, 2'd0, 1'b1, 32'hFFFFFFFE, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 16'd3,  16'd1, 16'd0);
    add_vec(1'b0, 1'b0, 2'd0, 1'b1, 32'hFFFFFFFE, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b1, 16'd4,  16'd2, 16'd1);
    add_vec(1'b0, 1'b0, 2'd0, 1'b1, 32'h00000000, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0, 16'd4,  16'd3, 16'd1);
    add_vec(1'b0, 1'b1, 2'd3, 1'b1, 32'h00000001, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0, 16'd4,  16'd4, 16'd1);
    add_vec(1'b0, 1'b0, 2'd3, 1'b0, 32'h0,        1'b1, 32'h00000002, 1'b1, 1'b0, 1'b0, 16'd5,  16'd4, 16'd1);
    add_vec(1'b0, 1'b0, 2'd3, 1'b0, 32'h0,        1'b1, 32'h00000003, 1'b1, 1'b0, 1'b0, 16'd6,  16'd4, 16'd1);
    add_vec(1'b0, 1'b1, 2'd3, 1'b0, 32'h0,        1'b1, 32'h00000004, 1'b1, 1'b0, 1'b0, 16'd7,  16'd4, 16'd1);
    add_vec(1'b0, 1'b0, 2'd3, 1'b0, 32'h0,        1'b1, 32'h00000005, 1'b1, 1'b0, 1'b0, 16'd8,  16'd4, 16'd1);
    add_vec(1'b0, 1'b0, 2'd3, 1'b0, 32'h0,        1'b0, 32'h00000005, 1'b1, 1'b0, 1'b0, 16'd8,  16'd4, 16'd1);
    add_vec(1'b0, 1'b0, 2'd3, 1'b0, 32'h0,        1'b0, 32'h00000005, 1'b1, 1'b0, 1'b0, 16'd8,  16'd4, 16'd1);
    add_vec(1'b0, 1'b0, 2'd3, 1'b0, 32'h0,        1'b1, 32'h00000006, 1'b1, 1'b0, 1'b0, 16'd9,  16'd4, 16'd1);
    add_vec(1'b0, 1'b0, 2'd3, 1'b0, 32'h0,        1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0, 16'd10, 16'd4, 16'd1);
    add_vec(1'b0, 1'b0, 2'd3, 1'b0, 32'h0,        1'b1, 32'h00000008, 1'b1, 1'b0, 1'b0, 16'd11, 16'd4, 16'd1);
    add_vec(1'b0, 1'b0, 2'd3, 1'b0, 32'h0,        1'b1, 32'h00000009, 1'b1, 1'b0, 1'b0, 16'd12, 16'd4, 16'd1);
    add_vec(1'b0, 1'b0, 2'd3, 1'b1, 32'h00000002, 1'b0, 32'h00000009, 1'b0, 1'b1, 1'b0, 16'd12, 16'd5, 16'd1);
    add_vec(1'b0, 1'b1, 2'd1, 1'b1, 32'h12345678, 1'b0, 32'h00000009, 1'b0, 1'b1, 1'b0, 16'd0,  16'd0, 16'd0);
    add_vec(1'b0, 1'b0, 2'd1, 1'b1, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 16'd1,  16'd1, 16'd0);
    add_vec(1'b0, 1'b0, 2'd1, 1'b1, 32'hEEEEEEED, 1'b1, 32'hEEEEEEED, 1'b1, 1'b0, 1'b0, 16'd2,  16'd2, 16'd0);
    add_vec(1'b1, 1'b0, 2'd1, 1'b0, 32'h0,        1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 16'd0,  16'd0, 16'd0);
    add_vec(1'b0, 1'b1, 2'd0, 1'b0, 32'h0,        1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 16'd0,  16'd0, 16'd0);
    add_vec(1'b0, 1'b0, 2'd0, 1'b1, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0, 16'd1,  16'd1, 16'd0);
    add_vec(1'b0, 1'b0, 2'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 16'd2,  16'd2, 16'd0);

    foreach (vq[i]) begin
      @(negedge clk);
      reset   = vq[i].rst;
      start_a = vq[i].start;
      mode_a  = vq[i].mode;
      rxv_a   = vq[i].rxv;
      rxd_a   = vq[i].rxd;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i),
            {44'd0, valid_a, data_a, busy_a, done_a, mm_a, tx_a, rx_a, err_a},
            {44'd0, vq[i].ev, vq[i].ed, vq[i].eb, vq[i].edn, vq[i].emm, vq[i].etx, vq[i].erx, vq[i].eerr});
    end
    @(negedge clk);
    start_a = 1'b0; rxv_a = 1'b0;

    // Zero-seed LFSR substitutes 1; back-to-back bursts end in DONE.
    b_run("lfsr", 2'b10, {32'h60180001, 32'hC0300002, 32'h80200003, 32'h00000001});

    // Wrong late words in DONE: each is a mismatch, rx_count saturates at 7.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rxv_b = 1'b1; rxd_b = 32'h0;
      @(posedge clk); #1;
      if (i == 0) begin
        check("sat_first", {119'd0, mm_b, rx_b, err_b}, {119'd0, 1'b1, 3'd5, 3'd1});
      end else if (i == 3) begin
        check("sat_last", {119'd0, mm_b, rx_b, err_b}, {119'd0, 1'b1, 3'd7, 3'd4});
      end
    end
    @(negedge clk);
    rxv_b = 1'b0;
    @(posedge clk); #1;
    check("sat_idle", {119'd0, mm_b, rx_b, err_b}, {119'd0, 1'b0, 3'd7, 3'd4});

    // Restart from DONE in decrement mode; zero seed wraps below 0.
    b_run("dec", 2'b01, {32'hCCCCCCCD, 32'hDDDDDDDE, 32'hEEEEEEEF, 32'h00000000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gen_chk_phy_tx.md
Name: gen_chk_phy_tx

Overview:
- Synthesizable, parametrised traffic generator and loopback checker for the phy_tx path. Replaces hand-scripted stimulus sequences.
- Generator emits bursts of DATA_W-bit words with valid. Burst length, gap length, burst count and data pattern are configurable.
- Checker regenerates the same sequence independently and compares it against words returned from the receive path. It counts tx words, rx words and mismatches.
- Sits beside phy_tx/phy_rx in the single-clock (clk) domain. Usable both in benches and on hardware.

Parameters:
- DATA_W, 32, word width.
- BURST_LEN, 4, valid words per burst (>=1).
- GAP_LEN, 2, idle cycles between bursts (0 = back-to-back bursts).
- NUM_BURSTS, 3, bursts per run (0 = run until reset).
- SEED, 32'hFFFFFFFF, first word of each run (truncated to DATA_W).
- STEP, 32'h11111111, decrement step for mode 01.
- POLY, 32'h80200003, Galois LFSR taps for mode 10.
- CNT_W, 16, width of the tx, rx and error counters.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- mode  in  2  pattern: 00 increment by 1, 01 decrement by STEP, 10 LFSR, 11 constant SEED. Latched on start.
- data_out_tx  out  DATA_W  generated word.
- valid_out_tx  out  1  data_out_tx valid.
- busy  out  1  high in BURST or GAP.
- done  out  1  high in DONE.
- data_in_rx  in  DATA_W  returned word.
- valid_in_rx  in  1  data_in_rx valid.
- mismatch  out  1  one-cycle pulse, one cycle after a bad compare.
- tx_count  out  CNT_W  words sent this run.
- rx_count  out  CNT_W  words checked this run.
- err_count  out  CNT_W  mismatches this run.

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high):
  - state goes to IDLE.
  - data_out_tx=0; valid_out_tx, busy, done and mismatch are 0.
  - All counters are 0; both generators are loaded with SEED.
- FSM states: IDLE, BURST, GAP, DONE.
  - IDLE/DONE: on start=1, latch mode, load both generators with SEED, clear counters and burst index, go to BURST. With start=0, hold state.
  - BURST: valid_out_tx=1 every cycle. Generator advances after each word; tx_count increments.
  - After the BURST_LEN-th word: if bursts completed == NUM_BURSTS (NUM_BURSTS != 0), go to DONE. Otherwise go to GAP, or go straight to BURST when GAP_LEN=0.
  - GAP: valid_out_tx=0 and data_out_tx holds its last value for GAP_LEN cycles, then return to BURST.
  - DONE: done=1 and valid_out_tx=0 until start or reset.
- Latency: start sampled at edge N gives valid_out_tx=1 with the first word (SEED) after edge N+1.
- start while busy is ignored; mode changes mid-run are ignored.
- Arithmetic is modulo 2^DATA_W:
  - Mode 00 wraps from all-ones to 0.
  - Mode 01 wraps below 0.
  - Mode 10 shifts right; if the LSB was 1, the result is XORed with POLY.
  - Mode 10 with a zero seed substitutes 1 (no lock-up).
- Checker: on each valid_in_rx=1 cycle, compare data_in_rx against the expected generator, then advance that generator and increment rx_count.
  - On inequality, increment err_count and pulse mismatch on the next cycle.
  - The checker runs in any state, including DONE and IDLE after a run, so late loopback words are still checked.
- Counters saturate at all-ones (no wrap).
- A start accepted in the same cycle as valid_in_rx=1: that word is discarded (not counted, not compared), and the checker restarts from SEED.
- NUM_BURSTS=0: the generator never enters DONE.

Test Plan:
- mode=01, SEED=FFFFFFFF, STEP=11111111, NUM_BURSTS=1, loopback tx->rx with 3-cycle delay -> words FFFFFFFF, EEEEEEEE, DDDDDDDD, CCCCCCCC on 4 consecutive cycles, then done=1. Final counts: tx_count=4, rx_count=4, err_count=0.
- Default params, mode=00, SEED=FFFFFFFE -> 3 bursts of 4 words with 2-cycle gaps: FFFFFFFE, FFFFFFFF, 00000000, 00000001, gap, 00000002... Final tx_count=12, done=1.
- Loopback with bit 0 of the 2nd returned word flipped -> mismatch pulses once, one cycle after that word; err_count=1, rx_count=4.
- mode=10, SEED=0 -> first word 00000001, second word 80200003. Loopback gives err_count=0.
- Reset asserted during the 3rd word of burst 2 -> next cycle valid_out_tx=0, busy=0, all counters 0, state IDLE. A new start replays from SEED.
- start pulsed while busy, and mode changed mid-run -> no effect on the sequence or counts. start in DONE restarts the run and clears the counters.
